// File: rtl/event_timestamp_logger.sv
// event_timestamp_logger
//   Snapshots CHANNELS data buses each enabled clock, decides whether the
//   snapshot is worth logging (baseline / on-change / periodic), stamps it
//   with a free-running cycle counter and queues it in a first-word-fall-
//   through FIFO drained through a valid/ready port.
//
// Ports
//   clk, rst        single rising-edge clock, synchronous active-high reset
//   enable          capture enable; a low cycle forces a fresh baseline
//   log_mode        0 = log on change, 1 = log every PERIOD captures
//   sample_in       channel c in bits [c*DATA_W +: DATA_W]
//   out_valid       head record available
//   out_ready       consumer accepts the head record
//   out_ts          capture timestamp of the head record
//   out_mask        per-channel changed flags of the head record
//   out_data        snapshot of the head record
//   out_wrap        timestamp counter wrapped since the previous record
//   fifo_level      number of stored records
//   overflow_count  records dropped because the FIFO was full (saturating)
module event_timestamp_logger #(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 8,
  parameter int TS_W     = 32,
  parameter int DEPTH    = 16,
  parameter int PERIOD   = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         log_mode,
  input  logic [CHANNELS*DATA_W-1:0]   sample_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [TS_W-1:0]              out_ts,
  output logic [CHANNELS-1:0]          out_mask,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         out_wrap,
  output logic [$clog2(DEPTH):0]       fifo_level,
  output logic [15:0]                  overflow_count
);

  localparam int SNAP_W = CHANNELS * DATA_W;
  localparam int REC_W  = TS_W + CHANNELS + SNAP_W + 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int PCNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERIOD - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [TS_W-1:0]     ts_cnt_q, ts_cnt_d;
  logic                wrap_q, wrap_d;
  logic [SNAP_W-1:0]   cur_q, cur_d;
  logic [TS_W-1:0]     cap_ts_q, cap_ts_d;
  logic [CHANNELS-1:0] cap_mask_q, cap_mask_d;
  logic                cap_log_q, cap_log_d;
  logic                baseline_pending_q, baseline_pending_d;
  logic [PCNT_W-1:0]   period_cnt_q, period_cnt_d;
  logic                mode_q, mode_d;
  logic [REC_W-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [15:0]         ovf_q, ovf_d;
  logic [REC_W-1:0]    head_q, head_d;
  logic                valid_q, valid_d;

  logic [CHANNELS-1:0] chg_mask;
  logic [PCNT_W-1:0]   period_eff;
  logic                mode_chg, take_base;
  logic                pop, full, push_ok, drop;
  logic [REC_W-1:0]    new_rec;

  // Stage 1: capture and log decision. The change mask is formed against
  // the previous enabled capture (cur_q) while the new one is registered,
  // so the decision travels with the snapshot into the push stage.
  always_comb begin
    chg_mask = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      chg_mask[c] = sample_in[c*DATA_W +: DATA_W] != cur_q[c*DATA_W +: DATA_W];
    end
    // A mode switch restarts the period phase and forces a baseline,
    // effective for a capture taken on the switching edge itself.
    mode_chg   = log_mode != mode_q;
    take_base  = baseline_pending_q | mode_chg;
    period_eff = mode_chg ? '0 : period_cnt_q;

    mode_d             = log_mode;
    cur_d              = cur_q;
    cap_ts_d           = cap_ts_q;
    cap_mask_d         = cap_mask_q;
    cap_log_d          = 1'b0;
    baseline_pending_d = 1'b1;
    period_cnt_d       = period_eff;
    if (enable) begin
      cur_d              = sample_in;
      cap_ts_d           = ts_cnt_q;
      cap_mask_d         = take_base ? '1 : chg_mask;
      cap_log_d          = take_base | (log_mode ? (period_eff == '0) : (|chg_mask));
      baseline_pending_d = 1'b0;
      period_cnt_d       = (period_eff == PCNT_LAST) ? '0 : period_eff + 1'b1;
    end
  end

  // Stage 2: push into the FIFO and maintain the registered head record.
  always_comb begin
    new_rec  = {cap_ts_q, cap_mask_q, cur_q, wrap_q};
    pop      = valid_q & out_ready;
    full     = level_q == LVL_FULL;
    // A pop on the same edge frees the slot the push needs.
    push_ok  = cap_log_q & (~full | pop);
    drop     = cap_log_q & full & ~pop;
    level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_next  = rd_ptr_q + 1'b1;
    rd_ptr_d = pop ? rd_next : rd_ptr_q;
    valid_d  = level_d != '0;
    ovf_d    = drop ? sat_inc16(ovf_q) : ovf_q;

    // Head is held when the queue drains so out_* keep their last values.
    head_d = head_q;
    if (pop) begin
      if (level_q > LVL_W'(1)) begin
        head_d = mem_q[rd_next];
      end else if (push_ok) begin
        head_d = new_rec;
      end
    end else if (level_q == '0 && push_ok) begin
      head_d = new_rec;
    end

    ts_cnt_d = ts_cnt_q + 1'b1;
    // A wrap on the same edge as a push belongs to the next record.
    wrap_d   = (&ts_cnt_q) | (wrap_q & ~push_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_q           <= '0;
      wrap_q             <= 1'b0;
      cur_q              <= '0;
      cap_ts_q           <= '0;
      cap_mask_q         <= '0;
      cap_log_q          <= 1'b0;
      baseline_pending_q <= 1'b1;
      period_cnt_q       <= '0;
      mode_q             <= 1'b0;
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      level_q            <= '0;
      ovf_q              <= '0;
      head_q             <= '0;
      valid_q            <= 1'b0;
    end else begin
      ts_cnt_q           <= ts_cnt_d;
      wrap_q             <= wrap_d;
      cur_q              <= cur_d;
      cap_ts_q           <= cap_ts_d;
      cap_mask_q         <= cap_mask_d;
      cap_log_q          <= cap_log_d;
      baseline_pending_q <= baseline_pending_d;
      period_cnt_q       <= period_cnt_d;
      mode_q             <= mode_d;
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      level_q            <= level_d;
      ovf_q              <= ovf_d;
      head_q             <= head_d;
      valid_q            <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= new_rec;
    end
  end

  assign out_valid      = valid_q;
  assign out_ts         = head_q[REC_W-1 -: TS_W];
  assign out_mask       = head_q[SNAP_W+1 +: CHANNELS];
  assign out_data       = head_q[1 +: SNAP_W];
  assign out_wrap       = head_q[0];
  assign fifo_level     = level_q;
  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_event_timestamp_logger.sv
module tb_event_timestamp_logger;

  logic        clk = 1'b0;
  logic        rst, enable, log_mode, out_ready;
  logic [15:0] sample_in;
  logic        out_valid, out_wrap;
  logic [7:0]  out_ts;
  logic [1:0]  out_mask;
  logic [15:0] out_data;
  logic [2:0]  fifo_level;
  logic [15:0] overflow_count;

  event_timestamp_logger #(
    .CHANNELS(2), .DATA_W(8), .TS_W(8), .DEPTH(4), .PERIOD(3)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .log_mode(log_mode),
    .sample_in(sample_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_ts(out_ts), .out_mask(out_mask), .out_data(out_data),
    .out_wrap(out_wrap), .fifo_level(fifo_level),
    .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  ts;
    logic [1:0]  mask;
    logic [15:0] data;
    logic        wrap;
  } rec_t;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: spec rules applied once per clock edge.
  int          m_ts, m_pcnt, m_ovf;
  bit          m_bp, m_mode, m_wrap, pend_v;
  logic [15:0] m_last;
  rec_t        pend, m_hold;
  rec_t        mq[$];
  rec_t        seen[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int   sz;
    bit   pop, pushed, chg, base, logit;
    logic [1:0] mk;
    if (rst) begin
      mq.delete();
      pend_v = 0; m_ts = 0; m_bp = 1; m_pcnt = 0; m_mode = 0;
      m_wrap = 0; m_ovf = 0; m_last = '0; m_hold = '0;
      return;
    end
    sz = mq.size();
    pop = (sz > 0) && out_ready;
    pushed = 0;
    if (pop) void'(mq.pop_front());
    if (pend_v) begin
      if (sz < 4 || pop) begin
        pend.wrap = m_wrap;
        mq.push_back(pend);
        pushed = 1;
      end else if (m_ovf < 65535) begin
        m_ovf++;
      end
    end
    chg = (log_mode != m_mode);
    if (chg) begin
      m_pcnt = 0;
      m_bp = 1;
    end
    m_mode = log_mode;
    if (enable) begin
      base = m_bp;
      for (int c = 0; c < 2; c++) mk[c] = sample_in[c*8 +: 8] != m_last[c*8 +: 8];
      logit = base || (log_mode ? (m_pcnt == 0) : (mk != 2'b00));
      pend = '{ts: 8'(m_ts), mask: (base ? 2'b11 : mk), data: sample_in, wrap: 1'b0};
      pend_v = logit;
      m_last = sample_in;
      m_bp = 0;
      m_pcnt = (m_pcnt + 1) % 3;
    end else begin
      pend_v = 0;
      m_bp = 1;
    end
    if (pushed) m_wrap = 0;
    if (m_ts == 255) m_wrap = 1;
    m_ts = (m_ts + 1) % 256;
    if (mq.size() > 0) m_hold = mq[0];
  endtask

  task automatic tick();
    if (!rst && out_valid && out_ready)
      seen.push_back('{ts: out_ts, mask: out_mask, data: out_data, wrap: out_wrap});
    model_edge();
    @(posedge clk);
    #1;
    check("valid", 64'(out_valid), 64'(mq.size() > 0));
    check("level", 64'(fifo_level), 64'(mq.size()));
    check("overflow", 64'(overflow_count), 64'(m_ovf));
    check("head", 64'({out_ts, out_mask, out_data, out_wrap}), 64'(m_hold));
  endtask

  initial begin
    rst = 1; enable = 0; log_mode = 0; out_ready = 1; sample_in = '0;
    m_ts = 0; m_pcnt = 0; m_ovf = 0; m_bp = 1; m_mode = 0; m_wrap = 0;
    pend_v = 0; m_last = '0; m_hold = '0;

    // Reset state
    repeat (2) tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);

    // Baseline and change detect
    rst = 0; enable = 1; log_mode = 0; out_ready = 1;
    seen.delete();
    while (m_ts < 20) begin
      sample_in = (m_ts >= 10) ? 16'h0301 : 16'h0201;
      tick();
    end
    check("base_count", 64'(seen.size()), 64'd2);
    check("base_rec0", 64'(seen[0]), 64'({8'd0, 2'b11, 16'h0201, 1'b0}));
    check("base_rec1", 64'(seen[1]), 64'({8'd10, 2'b10, 16'h0301, 1'b0}));

    // Periodic mode
    rst = 1; tick(); rst = 0;
    log_mode = 1; sample_in = 16'h00AA; seen.delete();
    while (m_ts < 12) tick();
    check("per_count", 64'(seen.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("per_ts", 64'(seen[i].ts), 64'(3 * i));
      check("per_mask", 64'(seen[i].mask), (i == 0) ? 64'd3 : 64'd0);
    end

    // Overflow, then full with simultaneous pop
    rst = 1; tick(); rst = 0;
    log_mode = 0; sample_in = 16'h0000; out_ready = 1;
    repeat (3) tick();
    out_ready = 0; seen.delete();
    repeat (6) begin
      sample_in ^= 16'h0001;
      tick();
    end
    repeat (2) tick();
    check("ovf_level", 64'(fifo_level), 64'd4);
    check("ovf_count", 64'(overflow_count), 64'd2);
    sample_in ^= 16'h0001;
    tick();
    out_ready = 1;
    tick();
    out_ready = 0;
    check("fullpop_level", 64'(fifo_level), 64'd4);
    check("fullpop_ovf", 64'(overflow_count), 64'd2);
    out_ready = 1;
    repeat (6) tick();
    check("drain_count", 64'(seen.size()), 64'd5);
    for (int i = 0; i < 4; i++) begin
      check("drain_ts", 64'(seen[i].ts), 64'(3 + i));
      check("drain_data", 64'(seen[i].data), 64'((i % 2 == 0) ? 1 : 0));
    end
    check("tail_rec", 64'(seen[4]), 64'({8'd11, 2'b01, 16'h0001, 1'b0}));

    // Timestamp wrap
    rst = 1; tick(); rst = 0;
    sample_in = 16'h0000;
    repeat (260) tick();
    seen.delete();
    sample_in = 16'h0001;
    repeat (4) tick();
    sample_in = 16'h0002;
    repeat (4) tick();
    check("wrap_count", 64'(seen.size()), 64'd2);
    check("wrap_rec0", 64'(seen[0]), 64'({8'd4, 2'b01, 16'h0001, 1'b1}));
    check("wrap_rec1", 64'(seen[1]), 64'({8'd8, 2'b01, 16'h0002, 1'b0}));

    // Reset mid-operation
    out_ready = 0;
    repeat (3) begin
      sample_in ^= 16'h0100;
      tick();
    end
    tick();
    check("mid_level", 64'(fifo_level), 64'd3);
    rst = 1; tick(); rst = 0;
    check("mid_valid", 64'(out_valid), 64'd0);
    check("mid_level0", 64'(fifo_level), 64'd0);
    check("mid_ovf0", 64'(overflow_count), 64'd0);
    out_ready = 1;
    repeat (2) tick();
    check("post_valid", 64'(out_valid), 64'd1);
    check("post_ts", 64'(out_ts), 64'd0);
    check("post_mask", 64'(out_mask), 64'd3);

    // Randomized traffic against the model
    for (int n = 0; n < 700; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      enable    = ($urandom_range(0, 9) != 0);
      out_ready = $urandom_range(0, 1);
      if ($urandom_range(0, 29) == 0) log_mode = ~log_mode;
      if ($urandom_range(0, 2) == 0)
        sample_in = {6'd0, 2'($urandom_range(0, 3)), 6'd0, 2'($urandom_range(0, 3))};
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
